// File: rtl/dmem_bridge.sv
// ----------------------------------------------------------------------------
// dmem_bridge
//   Data-memory access unit between the Mem stage and a single-beat
//   req/gnt/rvalid data bus. It issues one bus transaction per load or store,
//   returns load data right-aligned in MemDataOut, and holds the pipeline
//   through StallOut until the access has finished.
//
// Ports
//   Clk, Rst_n       core clock, asynchronous active-low reset
//   LoadValidIn      Mem stage holds a load (RaddrIn, LoadSizeIn = funct3[1:0])
//   StoreValidIn     Mem stage holds a store (WaddrIn, WdataIn, WmaskIn size code)
//   MemDataOut       registered load data, right-aligned, held until next load
//   StallOut         hold the pipeline (combinational)
//   DoneOut/ErrOut   one-cycle completion pulse and coincident error flag
//   BusReq/BusWe/BusAddr/BusWdata/BusWstrb   registered bus request side
//   BusGnt/BusRvalid/BusRdata/BusErr          bus response side
// ----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        LoadValidIn,
  input  logic        StoreValidIn,
  input  logic [63:0] RaddrIn,
  input  logic [1:0]  LoadSizeIn,
  input  logic [63:0] WaddrIn,
  input  logic [63:0] WdataIn,
  input  logic [3:0]  WmaskIn,
  output logic [63:0] MemDataOut,
  output logic        StallOut,
  output logic        DoneOut,
  output logic        ErrOut,
  output logic        BusReq,
  output logic        BusWe,
  output logic [63:0] BusAddr,
  output logic [63:0] BusWdata,
  output logic [7:0]  BusWstrb,
  input  logic        BusGnt,
  input  logic        BusRvalid,
  input  logic [63:0] BusRdata,
  input  logic        BusErr
);

  // Counter is wide enough to hold TIMEOUT itself (a grant on the last REQ
  // cycle can carry the count one past TIMEOUT-1 into WAIT).
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_load;
  logic [2:0]    r_off;

  logic          w_is_load;
  logic          w_is_store;
  logic [63:0]   w_addr;
  logic [1:0]    w_size;
  logic          w_size_ok;
  logic          w_misalign;
  logic          w_legal;
  logic [2:0]    w_off;
  logic [7:0]    w_lanes;
  logic [7:0]    w_strb;
  logic [63:0]   w_wdata;
  logic [63:0]   w_rdata_al;
  logic          w_timeout;

  // Expand an 8-bit byte-lane mask into a 64-bit bit mask.
  function automatic logic [63:0] f_byte_mask(input logic [7:0] lanes);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{lanes[i]}};
    end
    return m;
  endfunction

  // Load wins if both valids are seen together; the store is dropped.
  assign w_is_load  = LoadValidIn;
  assign w_is_store = StoreValidIn & ~LoadValidIn;
  assign w_addr     = w_is_load ? RaddrIn : WaddrIn;
  assign w_off      = w_addr[2:0];

  // Decode access size, legality and the unshifted byte-lane mask.
  always_comb begin
    w_size    = 2'd0;
    w_size_ok = 1'b0;
    if (w_is_load) begin
      w_size    = LoadSizeIn;
      w_size_ok = 1'b1;
    end else begin
      case (WmaskIn)
        4'b0001: begin w_size = 2'd0; w_size_ok = 1'b1; end
        4'b0010: begin w_size = 2'd1; w_size_ok = 1'b1; end
        4'b0100: begin w_size = 2'd2; w_size_ok = 1'b1; end
        4'b1000: begin w_size = 2'd3; w_size_ok = 1'b1; end
        default: begin w_size = 2'd0; w_size_ok = 1'b0; end
      endcase
    end
  end

  // Natural alignment check and lane mask for the decoded size.
  always_comb begin
    w_misalign = 1'b0;
    w_lanes    = 8'h01;
    case (w_size)
      2'd0: begin w_misalign = 1'b0;           w_lanes = 8'h01; end
      2'd1: begin w_misalign = w_off[0];       w_lanes = 8'h03; end
      2'd2: begin w_misalign = |w_off[1:0];    w_lanes = 8'h0F; end
      2'd3: begin w_misalign = |w_off[2:0];    w_lanes = 8'hFF; end
      default: begin w_misalign = 1'b1;        w_lanes = 8'h00; end
    endcase
  end

  assign w_legal    = w_size_ok & ~w_misalign;
  // Aligned accesses never carry lanes past byte 7, so no overflow here.
  assign w_strb     = w_lanes << w_off;
  assign w_wdata    = (WdataIn & f_byte_mask(w_lanes)) << {w_off, 3'b000};
  assign w_rdata_al = BusRdata >> {r_off, 3'b000};
  assign w_timeout  = (r_cnt >= CW'(TIMEOUT - 1));

  // Stall drops in DONE so the pipeline advances past the finished access.
  assign StallOut = (LoadValidIn | StoreValidIn) & (r_state != S_DONE);

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_load  <= 1'b0;
      r_off      <= 3'd0;
      MemDataOut <= 64'd0;
      DoneOut    <= 1'b0;
      ErrOut     <= 1'b0;
      BusReq     <= 1'b0;
      BusWe      <= 1'b0;
      BusAddr    <= 64'd0;
      BusWdata   <= 64'd0;
      BusWstrb   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          DoneOut <= 1'b0;
          ErrOut  <= 1'b0;
          if (LoadValidIn | StoreValidIn) begin
            if (w_legal) begin
              r_state   <= S_REQ;
              r_cnt     <= '0;
              r_is_load <= w_is_load;
              r_off     <= w_off;
              BusReq    <= 1'b1;
              BusWe     <= w_is_store;
              BusAddr   <= {w_addr[63:3], 3'b000};
              BusWdata  <= w_is_store ? w_wdata : 64'd0;
              BusWstrb  <= w_is_store ? w_strb : 8'd0;
            end else begin
              // Illegal request: complete with error, never touch the bus.
              r_state <= S_DONE;
              DoneOut <= 1'b1;
              ErrOut  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (BusGnt) begin
            r_state <= S_WAIT;
            BusReq  <= 1'b0;
            r_cnt   <= r_cnt + CW'(1);
          end else if (w_timeout) begin
            r_state <= S_DONE;
            BusReq  <= 1'b0;
            DoneOut <= 1'b1;
            ErrOut  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (BusRvalid) begin
            r_state <= S_DONE;
            DoneOut <= 1'b1;
            ErrOut  <= BusErr;
            r_cnt   <= '0;
            if (r_is_load) begin
              MemDataOut <= BusErr ? 64'd0 : w_rdata_al;
            end else begin
              MemDataOut <= MemDataOut;
            end
          end else if (w_timeout) begin
            r_state <= S_DONE;
            DoneOut <= 1'b1;
            ErrOut  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Valids still present here belong to the finished access.
          r_state <= S_IDLE;
          DoneOut <= 1'b0;
          ErrOut  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          BusReq  <= 1'b0;
          DoneOut <= 1'b0;
          ErrOut  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// ----------------------------------------------------------------------------
// tb_dmem_bridge
//   Directed bench for dmem_bridge (TIMEOUT overridden to 4). Inputs change
//   and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_dmem_bridge;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        load_s, store_s;
  logic [63:0] raddr_s, waddr_s, wdata_s;
  logic [1:0]  lsize_s;
  logic [3:0]  wmask_s;
  logic [63:0] mem_data_s;
  logic        stall_s, done_s, err_s;
  logic        bus_req_s, bus_we_s;
  logic [63:0] bus_addr_s, bus_wdata_s;
  logic [7:0]  bus_wstrb_s;
  logic        bus_gnt_s, bus_rvalid_s, bus_err_s;
  logic [63:0] bus_rdata_s;

  int n_checks = 0;
  int n_bad    = 0;

  dmem_bridge #(.TIMEOUT(4)) dut (
    .Clk         (clk_s),
    .Rst_n       (rst_n_s),
    .LoadValidIn (load_s),
    .StoreValidIn(store_s),
    .RaddrIn     (raddr_s),
    .LoadSizeIn  (lsize_s),
    .WaddrIn     (waddr_s),
    .WdataIn     (wdata_s),
    .WmaskIn     (wmask_s),
    .MemDataOut  (mem_data_s),
    .StallOut    (stall_s),
    .DoneOut     (done_s),
    .ErrOut      (err_s),
    .BusReq      (bus_req_s),
    .BusWe       (bus_we_s),
    .BusAddr     (bus_addr_s),
    .BusWdata    (bus_wdata_s),
    .BusWstrb    (bus_wstrb_s),
    .BusGnt      (bus_gnt_s),
    .BusRvalid   (bus_rvalid_s),
    .BusRdata    (bus_rdata_s),
    .BusErr      (bus_err_s)
  );

  always #5 clk_s = ~clk_s;

  // Upstream must never present a load and a store together.
  always @(posedge clk_s) begin
    if (rst_n_s) begin
      assert (!(load_s && store_s)) else $error("load and store valid together");
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge; DUT is in IDLE for this cycle.
  task automatic issue(input bit ld, input logic [63:0] addr, input logic [1:0] lsz,
                       input logic [63:0] wd, input logic [3:0] wm);
    @(negedge clk_s);
    load_s  = ld;
    store_s = !ld;
    raddr_s = addr;
    waddr_s = addr;
    lsize_s = lsz;
    wdata_s = wd;
    wmask_s = wm;
    #1;
    check_eq("stall_idle", {63'd0, stall_s}, 64'd1);
    check_eq("req_idle", {63'd0, bus_req_s}, 64'd0);
  endtask

  // Zero-wait bus: grant in REQ, response in WAIT, then check the DONE cycle.
  task automatic bus_ok(input logic [63:0] exp_addr, input bit exp_we, input bit chk_wr,
                        input logic [63:0] exp_wd, input logic [7:0] exp_st,
                        input logic [63:0] rd, input bit berr);
    @(negedge clk_s);
    check_eq("req_high", {63'd0, bus_req_s}, 64'd1);
    check_eq("req_stall", {63'd0, stall_s}, 64'd1);
    check_eq("bus_addr", bus_addr_s, exp_addr);
    check_eq("bus_we", {63'd0, bus_we_s}, {63'd0, exp_we});
    if (chk_wr) begin
      check_eq("bus_wdata", bus_wdata_s, exp_wd);
      check_eq("bus_wstrb", {56'd0, bus_wstrb_s}, {56'd0, exp_st});
    end
    bus_gnt_s = 1'b1;
    @(negedge clk_s);
    bus_gnt_s = 1'b0;
    check_eq("wait_req_low", {63'd0, bus_req_s}, 64'd0);
    check_eq("wait_stall", {63'd0, stall_s}, 64'd1);
    bus_rvalid_s = 1'b1;
    bus_rdata_s  = rd;
    bus_err_s    = berr;
    @(negedge clk_s);
    bus_rvalid_s = 1'b0;
    bus_err_s    = 1'b0;
    check_eq("done_pulse", {63'd0, done_s}, 64'd1);
    check_eq("done_stall", {63'd0, stall_s}, 64'd0);
    check_eq("done_err", {63'd0, err_s}, {63'd0, berr});
  endtask

  // Drop valids after DONE and confirm the pulses end.
  task automatic finish_access();
    load_s  = 1'b0;
    store_s = 1'b0;
    @(negedge clk_s);
    check_eq("idle_done", {63'd0, done_s}, 64'd0);
    check_eq("idle_err", {63'd0, err_s}, 64'd0);
    check_eq("idle_stall", {63'd0, stall_s}, 64'd0);
  endtask

  initial begin
    rst_n_s = 1'b0;
    load_s = 1'b0; store_s = 1'b0;
    raddr_s = 64'd0; waddr_s = 64'd0; wdata_s = 64'd0;
    lsize_s = 2'd0; wmask_s = 4'd0;
    bus_gnt_s = 1'b0; bus_rvalid_s = 1'b0; bus_err_s = 1'b0;
    bus_rdata_s = 64'd0;
    #12;
    check_eq("rst_done", {63'd0, done_s}, 64'd0);
    check_eq("rst_req", {63'd0, bus_req_s}, 64'd0);
    check_eq("rst_addr", bus_addr_s, 64'd0);
    check_eq("rst_mem", mem_data_s, 64'd0);
    @(negedge clk_s);
    rst_n_s = 1'b1;

    // 1) dword load
    issue(1'b1, 64'h8000_0010, 2'd3, 64'd0, 4'd0);
    bus_ok(64'h8000_0010, 1'b0, 1'b0, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 1'b0);
    check_eq("t1_mem", mem_data_s, 64'h1122_3344_5566_7788);
    finish_access();

    // 2) byte load at offset 3
    issue(1'b1, 64'h8000_0013, 2'd0, 64'd0, 4'd0);
    bus_ok(64'h8000_0010, 1'b0, 1'b0, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 1'b0);
    check_eq("t2_mem", mem_data_s, 64'h0000_0011_2233_4455);
    finish_access();

    // 3) half store at offset 6, upper data bytes masked
    issue(1'b0, 64'h8000_0016, 2'd0, 64'hFFFF_FFFF_FFFF_ABCD, 4'b0010);
    bus_ok(64'h8000_0010, 1'b1, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0, 1'b0);
    check_eq("t3_mem_hold", mem_data_s, 64'h0000_0011_2233_4455);
    finish_access();

    // 3b) word store at offset 4
    issue(1'b0, 64'h8000_0024, 2'd0, 64'h1234_5678_DEAD_BEEF, 4'b0100);
    bus_ok(64'h8000_0020, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0, 1'b0);
    finish_access();

    // 4) misaligned word load: error without bus access
    issue(1'b1, 64'h8000_0002, 2'd2, 64'd0, 4'd0);
    @(negedge clk_s);
    check_eq("t4_req", {63'd0, bus_req_s}, 64'd0);
    check_eq("t4_done", {63'd0, done_s}, 64'd1);
    check_eq("t4_err", {63'd0, err_s}, 64'd1);
    check_eq("t4_stall", {63'd0, stall_s}, 64'd0);
    check_eq("t4_mem_hold", mem_data_s, 64'h0000_0011_2233_4455);
    finish_access();

    // 4b) store with non-one-hot size code
    issue(1'b0, 64'h8000_0010, 2'd0, 64'h55, 4'b0011);
    @(negedge clk_s);
    check_eq("t4b_req", {63'd0, bus_req_s}, 64'd0);
    check_eq("t4b_err", {63'd0, err_s}, 64'd1);
    finish_access();

    // 5) timeout with no grant
    issue(1'b1, 64'h8000_0018, 2'd3, 64'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_s);
      check_eq("t5_req_held", {63'd0, bus_req_s}, 64'd1);
      check_eq("t5_no_done", {63'd0, done_s}, 64'd0);
    end
    @(negedge clk_s);
    check_eq("t5_req_drop", {63'd0, bus_req_s}, 64'd0);
    check_eq("t5_done", {63'd0, done_s}, 64'd1);
    check_eq("t5_err", {63'd0, err_s}, 64'd1);
    finish_access();
    bus_rvalid_s = 1'b1;
    bus_rdata_s  = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk_s);
    bus_rvalid_s = 1'b0;
    check_eq("t5_stale_done", {63'd0, done_s}, 64'd0);
    check_eq("t5_stale_mem", mem_data_s, 64'h0000_0011_2233_4455);

    // 5b) half load at offset 6, then a load with bus error
    issue(1'b1, 64'h8000_0046, 2'd1, 64'd0, 4'd0);
    bus_ok(64'h8000_0040, 1'b0, 1'b0, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 1'b0);
    check_eq("t5b_mem", mem_data_s, 64'h0000_0000_0000_1122);
    finish_access();
    issue(1'b1, 64'h8000_0048, 2'd3, 64'd0, 4'd0);
    bus_ok(64'h8000_0048, 1'b0, 1'b0, 64'd0, 8'd0, 64'hFFFF_0000_FFFF_0000, 1'b1);
    check_eq("t5b_err_mem", mem_data_s, 64'd0);
    finish_access();

    // 6) reset during WAIT
    issue(1'b1, 64'h8000_0020, 2'd3, 64'd0, 4'd0);
    @(negedge clk_s);
    check_eq("t6_req", {63'd0, bus_req_s}, 64'd1);
    bus_gnt_s = 1'b1;
    @(negedge clk_s);
    bus_gnt_s = 1'b0;
    rst_n_s   = 1'b0;
    load_s    = 1'b0;
    #1;
    check_eq("t6_rst_addr", bus_addr_s, 64'd0);
    check_eq("t6_rst_req", {63'd0, bus_req_s}, 64'd0);
    check_eq("t6_rst_stall", {63'd0, stall_s}, 64'd0);
    check_eq("t6_rst_done", {63'd0, done_s}, 64'd0);
    @(negedge clk_s);
    rst_n_s      = 1'b1;
    bus_rvalid_s = 1'b1;
    bus_rdata_s  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk_s);
    bus_rvalid_s = 1'b0;
    check_eq("t6_late_done", {63'd0, done_s}, 64'd0);
    check_eq("t6_late_mem", mem_data_s, 64'd0);
    issue(1'b1, 64'h8000_0008, 2'd3, 64'd0, 4'd0);
    bus_ok(64'h8000_0008, 1'b0, 1'b0, 64'd0, 8'd0, 64'hCAFE_BABE_0123_4567, 1'b0);
    check_eq("t6_mem", mem_data_s, 64'hCAFE_BABE_0123_4567);
    finish_access();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
